gpu_cmd_dispatcher: RTL

//  Host-side launch queue that sits directly upstream of the mini-GPU start/kernel_id/work_items/busy/done port.

---
 rtl/gpu_cmd_dispatcher.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/gpu_cmd_dispatcher.sv
// Kernel-launch queue in front of the mini-GPU start/busy/done port.
// Buffers host commands, issues them one at a time, counts completions and aborts hung kernels.
module gpu_cmd_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [31:0]              cmd_kernel_id,
    input  logic [31:0]              cmd_work_items,
    output logic                     gpu_start,
    output logic [31:0]              gpu_kernel_id,
    output logic [31:0]              gpu_work_items,
    input  logic                     gpu_busy,
    input  logic                     gpu_done,
    output logic                     idle,
    output logic [$clog2(DEPTH):0]   queue_level,
    output logic [CNT_W-1:0]         completed_count,
    output logic [CNT_W-1:0]         timeout_count,
    output logic                     irq,
    input  logic                     irq_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_RUN,
        S_DONE,
        S_ABORT
    } state_t;

    state_t            r_state;
    logic [31:0]       r_mem_id [DEPTH];
    logic [31:0]       r_mem_wi [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [31:0]       r_wd;
    logic              r_start;
    logic [31:0]       r_kid;
    logic [31:0]       r_wi;
    logic [CNT_W-1:0]  r_completed;
    logic [CNT_W-1:0]  r_timeouts;
    logic              r_irq;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_head_id;
    logic [31:0]       w_head_wi;
    logic              w_wd_hit;

    // Readiness depends on the level only, so a same-cycle pop never frees a slot for a push.
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_head_id = r_mem_id[r_rd_ptr];
    assign w_head_wi = r_mem_wi[r_rd_ptr];

    // The watchdog counts the cycles after LAUNCH; the +2 places ABORT exactly TIMEOUT cycles after it.
    assign w_wd_hit  = (TIMEOUT != 0) && ((r_wd + 32'd2) >= 32'(TIMEOUT));

    assign cmd_ready       = !w_full;
    assign queue_level     = r_level;
    assign idle            = w_empty && (r_state == S_IDLE);
    assign gpu_start       = r_start;
    assign gpu_kernel_id   = r_kid;
    assign gpu_work_items  = r_wi;
    assign completed_count = r_completed;
    assign timeout_count   = r_timeouts;
    assign irq             = r_irq;

    // Command storage; the contents need no reset because the level guards every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_id[r_wr_ptr] <= cmd_kernel_id;
            r_mem_wi[r_wr_ptr] <= cmd_work_items;
        end
    end

    // FIFO pointers and level; the pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    // Launch sequencer with watchdog, counters and the sticky interrupt (a set overrides a clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wd        <= '0;
            r_start     <= 1'b0;
            r_kid       <= '0;
            r_wi        <= '0;
            r_completed <= '0;
            r_timeouts  <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (irq_clear) begin
                r_irq <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_kid <= w_head_id;
                        r_wi  <= w_head_wi;
                        if (w_head_wi == 32'd0) begin
                            r_completed <= r_completed + CNT_W'(1);
                            r_irq       <= 1'b1;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    r_wd <= r_wd + 32'd1;
                    if (gpu_done) begin
                        r_state <= S_DONE;
                    end else if (w_wd_hit) begin
                        r_state <= S_ABORT;
                    end else if (gpu_busy) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_wd <= r_wd + 32'd1;
                    if (gpu_done) begin
                        r_state <= S_DONE;
                    end else if (w_wd_hit) begin
                        r_state <= S_ABORT;
                    end
                end
                S_DONE: begin
                    r_completed <= r_completed + CNT_W'(1);
                    r_irq       <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_ABORT: begin
                    if (r_timeouts != '1) begin
                        r_timeouts <= r_timeouts + CNT_W'(1);
                    end
                    r_irq   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
